fetch_queue: RTL

Instruction fetch front-end that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues word requests to an instruction memory with a variable response latency.
- Buffers returned instructions, paired with their PC+4, in a small in-order FIFO and presents them to the decode stage under a valid/ready handshake.
- Flushes all buffered and in-flight fetches when the MEM-stage branch/jump logic signals a redirect.

---
 rtl/fetch_queue_if.sv | 22 ++
 rtl/fetch_queue.sv | 69 ++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory request/response, redirect and decode dequeue signals of the fetch queue.
interface fetch_queue_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        deq_valid;
   logic        deq_ready;
   logic [31:0] deq_instr;
   logic [31:0] deq_pc4;
   modport master (
      output imem_req_valid, imem_req_addr, deq_valid, deq_instr, deq_pc4,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, deq_ready
   );
   modport slave (
      input  imem_req_valid, imem_req_addr, deq_valid, deq_instr, deq_pc4,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, deq_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, issues credit-limited imem requests and queues {pc4, instr} for decode.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic           clk,
   input logic           reset,
   fetch_queue_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [31:0]   r_fetch_pc, r_rsp_pc;
   logic [63:0]   r_mem [DEPTH];
   logic [AW-1:0] r_rd, r_wr;
   logic [CW-1:0] r_count, r_out, r_drop;
   logic [CW:0]   w_credit;
   logic [31:0]   w_target;
   logic [63:0]   w_rsp_entry;
   logic          w_accept, w_keep, w_push, w_pop, w_empty, w_bypass;
   // buffered plus in-flight fetches never exceed DEPTH, so the FIFO cannot overflow
   assign w_credit = {1'b0, r_count} + {1'b0, r_out};
   assign bus.imem_req_valid = !reset && !bus.redirect_valid && (w_credit < (CW+1)'(DEPTH));
   assign bus.imem_req_addr  = r_fetch_pc;
   assign w_accept    = bus.imem_req_valid && bus.imem_req_ready;
   assign w_keep      = bus.imem_rsp_valid && (r_drop == '0);
   assign w_empty     = (r_count == '0);
   assign w_target    = bus.redirect_pc & ~32'd3;
   assign w_rsp_entry = {r_rsp_pc + 32'd4, bus.imem_rsp_data};
`ifdef FETCH_QUEUE_BYPASS_EN
   assign w_bypass = w_empty && w_keep;
`else
   assign w_bypass = 1'b0;
`endif
   assign bus.deq_valid = !w_empty || w_bypass;
   assign {bus.deq_pc4, bus.deq_instr} = w_bypass ? w_rsp_entry : w_empty ? 64'd0 : r_mem[r_rd];
   assign w_pop  = !w_empty && bus.deq_ready;
   assign w_push = w_keep && !(w_bypass && bus.deq_ready);
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_pc <= RESET_PC;
         r_rsp_pc   <= RESET_PC;
         r_rd       <= '0;
         r_wr       <= '0;
         r_count    <= '0;
         r_out      <= '0;
         r_drop     <= '0;
      end else if (bus.redirect_valid) begin
         r_fetch_pc <= w_target;
         r_rsp_pc   <= w_target;
         r_rd       <= '0;
         r_wr       <= '0;
         r_count    <= '0;
         r_out      <= r_out - CW'(bus.imem_rsp_valid);
         r_drop     <= r_out - CW'(bus.imem_rsp_valid);
      end else begin
         if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
         if (w_keep) r_rsp_pc <= r_rsp_pc + 32'd4;
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop) r_rd <= r_rd + AW'(1);
         if (bus.imem_rsp_valid && !w_keep) r_drop <= r_drop - CW'(1);
         r_out   <= r_out + CW'(w_accept) - CW'(bus.imem_rsp_valid);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (!reset && !bus.redirect_valid && w_push) r_mem[r_wr] <= w_rsp_entry;
   end
endmodule
